cache_ctrl: RTL and testbench
=============================

Name: cache_ctrl

Overview:
Request sequencer between the CPU-side word interface and the cache_data/mem pair. Accepts one read/write request at a time and drives the cache lookup. On a miss it writes back a dirty victim to mem, refills the line from mem, installs it and replays the lookup. Keeps saturating hit/miss statistics.

Parameters:
MEM_LAT, 2, mem read/write latency in cycles after the strobe cycle (legal 1..15)
CNT_W, 16, width of hit/miss statistic counters

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  reset, asynchronous, active-low
cpu_req_valid  in  1  request present
cpu_req_we  in  1  1=write, 0=read
cpu_req_addr  in  PA_WIDTH  byte address
cpu_req_wdata  in  WRD_WIDTH  write word
cpu_req_ready  out  1  controller can accept a request
cpu_resp_valid  out  1  one-cycle response strobe
cpu_resp_rdata  out  WRD_WIDTH  read word (0 for writes)
cpu_resp_err  out  1  replay lookup missed
cache_rd_en  out  1  cache lookup strobe
cache_wr_en  out  1  word write into hit line
cache_addr  out  PA_WIDTH  latched request address
cache_wdata  out  WRD_WIDTH  latched write word
cache_hit  in  1  lookup hit, valid same cycle as cache_rd_en
cache_dirty  in  1  victim line dirty, valid with cache_hit=0
cache_victim_tag  in  TAG_WIDTH  victim tag
cache_victim_blk  in  BLK_WIDTH  victim data
cache_fill_en  out  1  install fill block, sets valid, clears dirty
cache_fill_blk  out  BLK_WIDTH  registered refill block
mem_addr  out  PA_WIDTH  block-aligned mem address
mem_rd_en  out  1  mem read strobe
mem_wr_en  out  1  mem write strobe
mem_wr_blk  out  BLK_WIDTH  writeback block
mem_rd_blk  in  BLK_WIDTH  mem read data
hit_cnt  out  CNT_W  first-lookup hits, saturating
miss_cnt  out  CNT_W  first-lookup misses, saturating

Behaviour:
- Reset (asynchronous, immediate): state IDLE; all outputs 0 except cpu_req_ready=1; counters 0; latched request and fill register 0. Reset mid-operation abandons it; mem strobes drop the same instant.
- cpu_req_ready = (state==IDLE). A request is accepted on valid&ready; addr, we and wdata are latched. Inputs are ignored outside IDLE.
- IDLE -> LOOKUP on accept.
- LOOKUP, 1 cycle: cache_rd_en=1.
  - hit: cache_wr_en = latched we, same cycle. cpu_resp_rdata is registered from cache word output for reads, 0 for writes. Next state RESP.
  - miss, cache_dirty=1: latch victim tag and block. Next state WRITEBACK.
  - miss, clean: next state REFILL.
  - miss during the replay lookup: next state RESP with cpu_resp_err=1.
- WRITEBACK, MEM_LAT+1 cycles: a 4-bit counter starts at 0. mem_wr_en=1 only at cnt==0. mem_addr = {victim_tag, index, OFFSET zeros}; mem_wr_blk = latched victim block. At cnt==MEM_LAT, go to REFILL.
- REFILL, MEM_LAT+1 cycles: mem_rd_en=1 only at cnt==0. mem_addr = request address with the low OFFSET_WIDTH bits cleared. At cnt==MEM_LAT, capture mem_rd_blk into cache_fill_blk and go to INSTALL.
- INSTALL, 1 cycle: cache_fill_en=1. Set the replay flag. Go to LOOKUP.
- RESP, 1 cycle: cpu_resp_valid=1; cpu_resp_err as set. Clear the replay flag. Go to IDLE, so ready rises the next cycle. No back-to-back accept in RESP.
- Statistics: only non-replay lookups count. hit_cnt increments on hit, miss_cnt on miss. Both hold at 2^CNT_W-1.
- mem_rd_en and mem_wr_en are never high together. At most one strobe per mem transaction.
- Latency, accept at cycle 0, L=MEM_LAT:
  - hit: resp_valid at cycle 2
  - clean miss: cycle L+5
  - dirty miss: cycle 2L+6
- cache_addr and cache_wdata hold the latched values from accept until return to IDLE.

Decomposition:
- Shared package cache_pkg:
  - PA_WIDTH, WRD_WIDTH, BLK_WIDTH, BYTE
  - OFFSET_WIDTH (6, 64-byte block), INDEX_WIDTH, TAG_WIDTH = PA_WIDTH-INDEX_WIDTH-OFFSET_WIDTH
  - ctrl_state_t enum: IDLE, LOOKUP, WRITEBACK, REFILL, INSTALL, RESP
- One sub-module: cache_sat_cnt, a parameterised saturating counter with inc and async clear, instanced twice.

Test Plan:
- Hit: preloaded line, read 0x0000_0004, L=2 -> resp_valid at cycle 2, rdata = stored word, hit_cnt=1, no mem strobes.
- Clean miss: read 0x0000_0048, victim clean -> mem_rd_en one cycle with mem_addr=0x0000_0040; cache_fill_en once; resp_valid at cycle 7; miss_cnt=1, hit_cnt=0.
- Dirty miss: write 0x0000_1084 with wdata 0xDEADBEEF, victim_tag dirty -> mem_wr_en with victim address, then mem_rd_en with 0x0000_1080; cache_wr_en in the replay LOOKUP; resp_valid at cycle 10.
- Replay failure: force cache_hit=0 on the replay -> resp_valid with resp_err=1, miss_cnt incremented once.
- Saturation: CNT_W=2, five hits -> hit_cnt holds at 3.
- Reset in REFILL at cnt==1 -> mem_rd_en, mem_wr_en and fill_en are 0 immediately; ready=1 and counters 0 after release; the next request completes normally.

Source files
------------

// File: rtl/cache_pkg.sv
// Shared widths, address-field geometry and controller state encoding for the cache slice.
package cache_pkg;

  localparam int unsigned PA_WIDTH     = 32;
  localparam int unsigned WRD_WIDTH    = 32;
  localparam int unsigned BLK_WIDTH    = 512;
  localparam int unsigned BYTE         = 8;

  localparam int unsigned OFFSET_WIDTH = 6;
  localparam int unsigned INDEX_WIDTH  = 6;
  localparam int unsigned TAG_WIDTH    = PA_WIDTH - INDEX_WIDTH - OFFSET_WIDTH;

  localparam int unsigned WORDS_PER_BLK  = BLK_WIDTH / WRD_WIDTH;
  localparam int unsigned WORD_SEL_LSB   = $clog2(WRD_WIDTH / BYTE);
  localparam int unsigned WORD_SEL_WIDTH = OFFSET_WIDTH - WORD_SEL_LSB;

  typedef enum logic [2:0] {
    IDLE,
    LOOKUP,
    WRITEBACK,
    REFILL,
    INSTALL,
    RESP
  } ctrl_state_t;

  // Clear the byte offset so the address points at the start of its block.
  function automatic logic [PA_WIDTH-1:0] blk_align(input logic [PA_WIDTH-1:0] addr);
    return {addr[PA_WIDTH-1:OFFSET_WIDTH], {OFFSET_WIDTH{1'b0}}};
  endfunction

endpackage

// File: rtl/cache_sat_cnt.sv
// Saturating up-counter: increments on inc_i, sticks at all-ones, async clear on reset.
module cache_sat_cnt #(
  parameter int unsigned Width = 16
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             inc_i,
  output logic [Width-1:0] cnt_o
);

  logic [Width-1:0] cnt_q;

  // Count events until the counter reaches its maximum value, then hold.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else if (inc_i && (cnt_q != '1)) begin
      cnt_q <= cnt_q + Width'(1);
    end
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/cache_ctrl.sv
// Cache request sequencer: lookup, dirty writeback, refill, install and replay, plus hit/miss
// statistics on first lookups only.
module cache_ctrl import cache_pkg::*; #(
  parameter int unsigned MEM_LAT = 2,
  parameter int unsigned CNT_W   = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 cpu_req_valid,
  input  logic                 cpu_req_we,
  input  logic [PA_WIDTH-1:0]  cpu_req_addr,
  input  logic [WRD_WIDTH-1:0] cpu_req_wdata,
  output logic                 cpu_req_ready,
  output logic                 cpu_resp_valid,
  output logic [WRD_WIDTH-1:0] cpu_resp_rdata,
  output logic                 cpu_resp_err,
  output logic                 cache_rd_en,
  output logic                 cache_wr_en,
  output logic [PA_WIDTH-1:0]  cache_addr,
  output logic [WRD_WIDTH-1:0] cache_wdata,
  input  logic                 cache_hit,
  input  logic                 cache_dirty,
  input  logic [TAG_WIDTH-1:0] cache_victim_tag,
  input  logic [BLK_WIDTH-1:0] cache_victim_blk,
  output logic                 cache_fill_en,
  output logic [BLK_WIDTH-1:0] cache_fill_blk,
  output logic [PA_WIDTH-1:0]  mem_addr,
  output logic                 mem_rd_en,
  output logic                 mem_wr_en,
  output logic [BLK_WIDTH-1:0] mem_wr_blk,
  input  logic [BLK_WIDTH-1:0] mem_rd_blk,
  output logic [CNT_W-1:0]     hit_cnt,
  output logic [CNT_W-1:0]     miss_cnt
);

  localparam logic [3:0] LatLast = 4'(MEM_LAT);

  ctrl_state_t          state_q;
  logic [3:0]           cnt_q;
  logic [PA_WIDTH-1:0]  addr_q;
  logic                 we_q;
  logic [WRD_WIDTH-1:0] wdata_q;
  logic [TAG_WIDTH-1:0] vtag_q;
  logic [BLK_WIDTH-1:0] vblk_q;
  logic [BLK_WIDTH-1:0] fill_q;
  logic                 replay_q;
  logic [WRD_WIDTH-1:0] rdata_q;
  logic                 err_q;

  // The data array presents the indexed line on the victim bus whether or not it hits,
  // so a read hit takes its word from there.
  logic [WORDS_PER_BLK-1:0][WRD_WIDTH-1:0] line_words;
  logic [WORD_SEL_WIDTH-1:0]               word_sel;
  logic                                    lookup;
  logic                                    first_lookup;

  assign line_words   = cache_victim_blk;
  assign word_sel     = addr_q[OFFSET_WIDTH-1:WORD_SEL_LSB];
  assign lookup       = (state_q == LOOKUP);
  assign first_lookup = lookup && !replay_q;

  // Request sequencing FSM with its latched request, victim and fill registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      addr_q   <= '0;
      we_q     <= 1'b0;
      wdata_q  <= '0;
      vtag_q   <= '0;
      vblk_q   <= '0;
      fill_q   <= '0;
      replay_q <= 1'b0;
      rdata_q  <= '0;
      err_q    <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (cpu_req_valid) begin
            addr_q  <= cpu_req_addr;
            we_q    <= cpu_req_we;
            wdata_q <= cpu_req_wdata;
            state_q <= LOOKUP;
          end
        end
        LOOKUP: begin
          rdata_q <= (cache_hit && !we_q) ? line_words[word_sel] : '0;
          err_q   <= 1'b0;
          cnt_q   <= '0;
          if (cache_hit) begin
            state_q <= RESP;
          end else if (replay_q) begin
            // The freshly installed line should have hit; report it rather than loop.
            err_q   <= 1'b1;
            state_q <= RESP;
          end else if (cache_dirty) begin
            vtag_q  <= cache_victim_tag;
            vblk_q  <= cache_victim_blk;
            state_q <= WRITEBACK;
          end else begin
            state_q <= REFILL;
          end
        end
        WRITEBACK: begin
          if (cnt_q == LatLast) begin
            cnt_q   <= '0;
            state_q <= REFILL;
          end else begin
            cnt_q <= cnt_q + 4'd1;
          end
        end
        REFILL: begin
          if (cnt_q == LatLast) begin
            fill_q  <= mem_rd_blk;
            cnt_q   <= '0;
            state_q <= INSTALL;
          end else begin
            cnt_q <= cnt_q + 4'd1;
          end
        end
        INSTALL: begin
          replay_q <= 1'b1;
          state_q  <= LOOKUP;
        end
        RESP: begin
          replay_q <= 1'b0;
          state_q  <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Block-aligned memory address: victim location during writeback, request block on refill.
  always_comb begin
    mem_addr = '0;
    if (state_q == WRITEBACK) begin
      mem_addr = {vtag_q, addr_q[OFFSET_WIDTH +: INDEX_WIDTH], {OFFSET_WIDTH{1'b0}}};
    end else if (state_q == REFILL) begin
      mem_addr = blk_align(addr_q);
    end
  end

  assign cpu_req_ready  = (state_q == IDLE);
  assign cpu_resp_valid = (state_q == RESP);
  assign cpu_resp_rdata = rdata_q;
  assign cpu_resp_err   = (state_q == RESP) && err_q;

  assign cache_rd_en    = lookup;
  assign cache_wr_en    = lookup && cache_hit && we_q;
  assign cache_addr     = addr_q;
  assign cache_wdata    = wdata_q;
  assign cache_fill_en  = (state_q == INSTALL);
  assign cache_fill_blk = fill_q;

  assign mem_wr_en      = (state_q == WRITEBACK) && (cnt_q == 4'd0);
  assign mem_rd_en      = (state_q == REFILL) && (cnt_q == 4'd0);
  assign mem_wr_blk     = vblk_q;

  cache_sat_cnt #(
    .Width (CNT_W)
  ) u_hit_cnt (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .inc_i  (first_lookup && cache_hit),
    .cnt_o  (hit_cnt)
  );

  cache_sat_cnt #(
    .Width (CNT_W)
  ) u_miss_cnt (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .inc_i  (first_lookup && !cache_hit),
    .cnt_o  (miss_cnt)
  );

endmodule

// File: tb/tb_cache_ctrl.sv
// Self-checking bench for cache_ctrl: behavioural cache array and memory models, a response
// scoreboard, and directed hit / clean miss / dirty miss / replay failure / reset scenarios.
module tb_cache_ctrl;
  import cache_pkg::*;

  localparam int unsigned MEM_LAT = 2;
  localparam int unsigned CNT_W   = 2;

  logic                 clk;
  logic                 rst_n;
  logic                 cpu_req_valid;
  logic                 cpu_req_we;
  logic [PA_WIDTH-1:0]  cpu_req_addr;
  logic [WRD_WIDTH-1:0] cpu_req_wdata;
  logic                 cpu_req_ready;
  logic                 cpu_resp_valid;
  logic [WRD_WIDTH-1:0] cpu_resp_rdata;
  logic                 cpu_resp_err;
  logic                 cache_rd_en;
  logic                 cache_wr_en;
  logic [PA_WIDTH-1:0]  cache_addr;
  logic [WRD_WIDTH-1:0] cache_wdata;
  logic                 cache_hit;
  logic                 cache_dirty;
  logic [TAG_WIDTH-1:0] cache_victim_tag;
  logic [BLK_WIDTH-1:0] cache_victim_blk;
  logic                 cache_fill_en;
  logic [BLK_WIDTH-1:0] cache_fill_blk;
  logic [PA_WIDTH-1:0]  mem_addr;
  logic                 mem_rd_en;
  logic                 mem_wr_en;
  logic [BLK_WIDTH-1:0] mem_wr_blk;
  logic [BLK_WIDTH-1:0] mem_rd_blk;
  logic [CNT_W-1:0]     hit_cnt;
  logic [CNT_W-1:0]     miss_cnt;

  cache_ctrl #(
    .MEM_LAT (MEM_LAT),
    .CNT_W   (CNT_W)
  ) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .cpu_req_valid    (cpu_req_valid),
    .cpu_req_we       (cpu_req_we),
    .cpu_req_addr     (cpu_req_addr),
    .cpu_req_wdata    (cpu_req_wdata),
    .cpu_req_ready    (cpu_req_ready),
    .cpu_resp_valid   (cpu_resp_valid),
    .cpu_resp_rdata   (cpu_resp_rdata),
    .cpu_resp_err     (cpu_resp_err),
    .cache_rd_en      (cache_rd_en),
    .cache_wr_en      (cache_wr_en),
    .cache_addr       (cache_addr),
    .cache_wdata      (cache_wdata),
    .cache_hit        (cache_hit),
    .cache_dirty      (cache_dirty),
    .cache_victim_tag (cache_victim_tag),
    .cache_victim_blk (cache_victim_blk),
    .cache_fill_en    (cache_fill_en),
    .cache_fill_blk   (cache_fill_blk),
    .mem_addr         (mem_addr),
    .mem_rd_en        (mem_rd_en),
    .mem_wr_en        (mem_wr_en),
    .mem_wr_blk       (mem_wr_blk),
    .mem_rd_blk       (mem_rd_blk),
    .hit_cnt          (hit_cnt),
    .miss_cnt         (miss_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [511:0] got, input logic [511:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Memory content is a pure function of the block address.
  function automatic logic [BLK_WIDTH-1:0] blk_pat(input logic [31:0] a);
    logic [BLK_WIDTH-1:0] r;
    for (int i = 0; i < 16; i++) r[i*32 +: 32] = a ^ (32'h1111_1111 * i) ^ 32'hA5A5_0000;
    return r;
  endfunction

  // ---------------- cache array model ----------------
  logic                 valid_m [64] = '{default: 1'b0};
  logic                 dirty_m [64] = '{default: 1'b0};
  logic [TAG_WIDTH-1:0] tag_m   [64];
  logic [BLK_WIDTH-1:0] data_m  [64];
  logic                 block_fill = 1'b0;
  logic                 pl_en = 1'b0;
  int                   pl_idx;
  logic [TAG_WIDTH-1:0] pl_tag;
  logic                 pl_dirty;
  logic [BLK_WIDTH-1:0] pl_data;

  logic [5:0]           m_idx;
  logic [TAG_WIDTH-1:0] m_tag;
  logic [3:0]           m_word;
  assign m_idx            = cache_addr[11:6];
  assign m_tag            = cache_addr[31:12];
  assign m_word           = cache_addr[5:2];
  assign cache_hit        = valid_m[m_idx] && (tag_m[m_idx] == m_tag);
  assign cache_dirty      = valid_m[m_idx] && dirty_m[m_idx];
  assign cache_victim_tag = tag_m[m_idx];
  assign cache_victim_blk = data_m[m_idx];

  // ---------------- memory model ----------------
  int            rd_age = 0;
  logic [31:0]   rd_addr_l = '0;
  assign mem_rd_blk = (rd_age == MEM_LAT) ? blk_pat(rd_addr_l) : ~blk_pat(rd_addr_l);

  always @(posedge clk) begin
    if (pl_en) begin
      valid_m[pl_idx] <= 1'b1;
      tag_m[pl_idx]   <= pl_tag;
      dirty_m[pl_idx] <= pl_dirty;
      data_m[pl_idx]  <= pl_data;
    end
    if (cache_fill_en && !block_fill) begin
      valid_m[m_idx] <= 1'b1;
      tag_m[m_idx]   <= m_tag;
      dirty_m[m_idx] <= 1'b0;
      data_m[m_idx]  <= cache_fill_blk;
    end
    if (cache_wr_en) begin
      data_m[m_idx][m_word*32 +: 32] <= cache_wdata;
      dirty_m[m_idx]                 <= 1'b1;
    end
    if (mem_rd_en) begin
      rd_age    <= 1;
      rd_addr_l <= mem_addr;
    end else if (rd_age != 0 && rd_age < 15) begin
      rd_age <= rd_age + 1;
    end
  end

  // ---------------- monitor and scoreboard ----------------
  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          lat;
    int          acc;
  } exp_t;
  exp_t exp_q[$];
  exp_t e_mon;

  int          wr_n = 0, rd_n = 0, fill_n = 0, cwr_n = 0, both_n = 0;
  int          wr_cyc = 0, rd_cyc = 0;
  logic [31:0] wr_addr = '0, rd_addr = '0;
  logic [BLK_WIDTH-1:0] wr_blk = '0;

  always @(negedge clk) begin
    if (!rst_n) begin
      exp_q.delete();
    end else begin
      if (mem_wr_en) begin
        wr_n++; wr_addr = mem_addr; wr_blk = mem_wr_blk; wr_cyc = cyc;
      end
      if (mem_rd_en) begin
        rd_n++; rd_addr = mem_addr; rd_cyc = cyc;
      end
      if (mem_rd_en && mem_wr_en) both_n++;
      if (cache_fill_en) fill_n++;
      if (cache_wr_en) cwr_n++;
      if (cpu_resp_valid) begin
        if (exp_q.size() == 0) begin
          check("unexpected_resp", 1, 0);
        end else begin
          e_mon = exp_q.pop_front();
          check("resp_rdata", cpu_resp_rdata, e_mon.rdata);
          check("resp_err", cpu_resp_err, e_mon.err);
          check("resp_latency", cyc - e_mon.acc, e_mon.lat);
        end
      end
    end
  end

  // ---------------- stimulus tasks ----------------
  task automatic preload(input int idx, input logic [TAG_WIDTH-1:0] tag, input logic dirty,
                         input logic [BLK_WIDTH-1:0] data);
    @(posedge clk); #1;
    pl_en = 1'b1; pl_idx = idx; pl_tag = tag; pl_dirty = dirty; pl_data = data;
    @(posedge clk); #1;
    pl_en = 1'b0;
  endtask

  task automatic do_req(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [31:0] exp_rdata, input logic exp_err, input int exp_lat);
    exp_t e;
    int   n;
    @(posedge clk); #1;
    cpu_req_valid = 1'b1; cpu_req_we = we; cpu_req_addr = addr; cpu_req_wdata = wdata;
    n = 0;
    @(negedge clk);
    while (!cpu_req_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    e.rdata = exp_rdata; e.err = exp_err; e.lat = exp_lat; e.acc = cyc;
    exp_q.push_back(e);
    @(posedge clk); #1;
    cpu_req_valid = 1'b0;
    n = 0;
    while (exp_q.size() != 0 && n < 200) begin
      @(negedge clk); #1;
      n++;
    end
    if (exp_q.size() != 0) begin
      check("resp_timeout", exp_q.size(), 0);
      exp_q.delete();
    end
  endtask

  logic [BLK_WIDTH-1:0] d0, v2;
  int rd0, wr0, fl0, cw0, n;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0; cpu_req_valid = 1'b0; cpu_req_we = 1'b0;
    cpu_req_addr = '0; cpu_req_wdata = '0;
    d0 = blk_pat(32'hC0DE_0000);
    v2 = blk_pat(32'h7777_0000);
    repeat (3) @(posedge clk);
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk);
    check("rst_ready", cpu_req_ready, 1);
    check("rst_resp_valid", cpu_resp_valid, 0);
    check("rst_rd_en", cache_rd_en, 0);
    check("rst_mem_strobes", {mem_rd_en, mem_wr_en}, 0);
    check("rst_cnts", {hit_cnt, miss_cnt}, 0);

    // Hit on a preloaded line.
    preload(0, '0, 1'b0, d0);
    preload(1, 20'h7, 1'b0, blk_pat(32'h0000_7040));
    preload(2, 20'h5, 1'b1, v2);
    rd0 = rd_n; wr0 = wr_n;
    do_req(1'b0, 32'h0000_0004, '0, d0[63:32], 1'b0, 2);
    check("hit_hit_cnt", hit_cnt, 1);
    check("hit_no_mem", (rd_n - rd0) + (wr_n - wr0), 0);

    // Clean miss.
    rd0 = rd_n; wr0 = wr_n; fl0 = fill_n;
    d0 = blk_pat(32'h0000_0040);
    do_req(1'b0, 32'h0000_0048, '0, d0[95:64], 1'b0, MEM_LAT + 5);
    check("clean_rd_strobes", rd_n - rd0, 1);
    check("clean_rd_addr", rd_addr, 32'h0000_0040);
    check("clean_wr_strobes", wr_n - wr0, 0);
    check("clean_fills", fill_n - fl0, 1);
    check("clean_fill_data", data_m[1], blk_pat(32'h0000_0040));
    check("clean_miss_cnt", miss_cnt, 1);
    check("clean_hit_cnt", hit_cnt, 1);

    // Dirty miss on a write.
    rd0 = rd_n; wr0 = wr_n; cw0 = cwr_n;
    do_req(1'b1, 32'h0000_1084, 32'hDEAD_BEEF, '0, 1'b0, 2 * MEM_LAT + 6);
    check("dirty_wr_strobes", wr_n - wr0, 1);
    check("dirty_wb_addr", wr_addr, 32'h0000_5080);
    check("dirty_wb_blk", wr_blk, v2);
    check("dirty_rd_strobes", rd_n - rd0, 1);
    check("dirty_rd_addr", rd_addr, 32'h0000_1080);
    check("dirty_wb_before_rd", wr_cyc < rd_cyc, 1);
    check("dirty_word_writes", cwr_n - cw0, 1);
    check("dirty_word", data_m[2][63:32], 32'hDEAD_BEEF);
    check("dirty_line_dirty", dirty_m[2], 1);
    check("dirty_miss_cnt", miss_cnt, 2);
    check("dirty_hit_cnt", hit_cnt, 1);

    // Replay lookup misses because the install is suppressed.
    block_fill = 1'b1;
    do_req(1'b0, 32'h0000_2000, '0, '0, 1'b1, MEM_LAT + 5);
    block_fill = 1'b0;
    check("replay_miss_cnt", miss_cnt, 3);
    check("replay_hit_cnt", hit_cnt, 1);
    check("never_both_strobes", both_n, 0);

    // Reset in the middle of a refill.
    @(posedge clk); #1;
    cpu_req_valid = 1'b1; cpu_req_we = 1'b0; cpu_req_addr = 32'h0000_3000;
    @(posedge clk); #1;
    cpu_req_valid = 1'b0;
    n = 0;
    while (!mem_rd_en && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("rst_test_refill_seen", mem_rd_en, 1);
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    check("async_rst_strobes", {mem_rd_en, mem_wr_en, cache_fill_en}, 0);
    check("async_rst_ready", cpu_req_ready, 1);
    check("async_rst_cnts", {hit_cnt, miss_cnt}, 0);
    check("async_rst_latch", cache_addr, 0);
    check("async_rst_fill", cache_fill_blk, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("post_rst_ready", cpu_req_ready, 1);
    d0 = blk_pat(32'hC0DE_0000);
    do_req(1'b0, 32'h0000_0004, '0, d0[63:32], 1'b0, 2);
    check("post_rst_hit_cnt", hit_cnt, 1);

    // Saturation of the 2-bit hit counter.
    for (int i = 0; i < 5; i++) begin
      do_req(1'b0, 32'(i * 4), '0, d0[i*32 +: 32], 1'b0, 2);
    end
    check("sat_hit_cnt", hit_cnt, 3);
    check("sat_miss_cnt", miss_cnt, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
